rob_multi_wb: RTL
=================

Name: rob_multi_wb

Overview:
- Parametrised reorder buffer. Successor to the single-port ROB.
- Configurable depth and number of write-back (CDB) channels.
- Occupancy counter gives exact full/empty; commits one entry per cycle in order.
- Adds a one-shot LSB commit handshake and a full pipeline flush on taken-branch commit.
- Sits between decode/dispatch (allocate, operand lookup) and register file / IF / LSB (commit, redirect).

Parameters:
DEPTH, 16, entry count; power of two, >=4
TAG_W, 4, log2(DEPTH)
N_WB, 3, number of write-back channels
REG_W, 5, architectural register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
rdy  in  1  global enable; low freezes all state and outputs
alloc_valid  in  1  allocate one entry at tail
alloc_type  in  3  0 REG, 1 LOAD, 2 STORE, 3 PC, 4 PCREG
alloc_dest  in  REG_W  destination register
alloc_tag  out  TAG_W  combinational = tail
full  out  1  combinational, count==DEPTH
empty  out  1  combinational, count==0
count  out  TAG_W+1  combinational occupancy
wb_valid  in  N_WB  per-channel write-back strobe
wb_tag  in  N_WB*TAG_W  packed tags, channel i at [i*TAG_W +: TAG_W]
wb_data  in  N_WB*32  packed result data
wb_taken  in  N_WB  branch redirect required
wb_pc  in  N_WB*32  redirect target
rd1_valid, rd2_valid  in  1  operand lookup request
rd1_tag, rd2_tag  in  TAG_W  lookup tag
rd1_hit, rd2_hit  out  1  combinational, value available
rd1_data, rd2_data  out  32  combinational lookup value, 0 when no hit
commit_valid  out  1  registered, register write pulse
commit_dest  out  REG_W  registered
commit_tag  out  TAG_W  registered
commit_data  out  32  registered
lsb_commit  out  1  registered one-cycle pulse
lsb_tag  out  TAG_W  registered, entry released to LSB
flush  out  1  registered one-cycle pulse
flush_pc  out  32  registered redirect PC

Behaviour:
- Reset (rst=0, async): head=tail=count=0; all ready/sent bits 0; every registered output 0.
- Allocate when alloc_valid && !full at the edge. Write the entry, ready=0, sent=0, tail wraps DEPTH-1→0. alloc_valid while full is ignored with no state change.
- Write-back: for each i with wb_valid[i], set ready[tag]=1 and store data, taken and pc.
  - taken is forced to 0 for any entry that is not type PC/PCREG.
  - Same tag on two channels: highest index wins.
- Lookup order for each port:
  1. Stored ready entry.
  2. Write-back channels 0..N_WB-1, same cycle; lowest index wins.
  3. Otherwise miss.
  - rd2 uses rd2_tag everywhere.
- Commit condition: count!=0 && ready[head].
  - Advance head (wraps) and decrement count.
  - REG, LOAD, PCREG: commit_valid=1 with dest/tag/data.
  - STORE, PC: commit_valid=0.
  - Earliest commit edge is the one after the write-back edge.
- LSB handshake: when count!=0, head is LOAD/STORE and sent[head]=0, pulse lsb_commit with lsb_tag=head and set sent[head]. The entry then waits for its write-back.
- Commit of PC/PCREG with taken=1:
  - Same edge: flush=1, flush_pc=pc; head=tail=count=0; all ready/sent cleared.
  - Same-edge allocation and write-backs are discarded.
  - A PCREG entry still produces its commit_valid.
- Simultaneous allocate and commit: count unchanged. full never blocks commit.
- Non-commit cycles: commit_valid=0 and flush=0. lsb_commit is 0 unless newly issued.
- rdy=0: nothing updates, including pulses; outputs hold.

Optional Feature:
ROB_WB_BYPASS_EN
- Defined: lookup steps 2 and 3 active as above.
- Undefined: lookup hits only stored ready entries. Same-cycle write-back is visible from the next cycle.

Test Plan:
- Reset then 16 allocs of REG → full=1 at count=16, alloc_tag 0..15; 17th alloc ignored, tail unchanged.
- Alloc REG x5 tag0; wb ch2 tag0 data 0xABCD → next edge commit_valid=1, dest=5, data=0xABCD; empty=1.
- Alloc tags 0,1; wb tag1 first → no commit until tag0 written back; then commits in order 0,1 on consecutive edges.
- Alloc STORE tag0 → lsb_commit pulse once, lsb_tag=0; no repeat while waiting; wb tag0 → commit_valid=0, head→1.
- Alloc PC, REG, REG; wb tag0 taken=1 pc=0x1000 → flush=1, flush_pc=0x1000, count=0, pending wb of tag1 dropped.
- Lookup rd1_tag=3 with wb ch1 tag3 data 7 same cycle → rd1_hit=1, rd1_data=7 with bypass; rd1_hit=0 without it.

Source files
------------

// File: rtl/rob_multi_wb.sv
// Reorder buffer: N_WB write-back channels, in-order single commit, LSB release handshake and
// full flush on taken-branch commit. Define ROB_WB_BYPASS_EN to let lookups see same-cycle write-backs.
module rob_multi_wb #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4,
  parameter int N_WB  = 3,
  parameter int REG_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    alloc_valid,
  input  logic [2:0]              alloc_type,
  input  logic [REG_W-1:0]        alloc_dest,
  output logic [TAG_W-1:0]        alloc_tag,
  output logic                    full,
  output logic                    empty,
  output logic [TAG_W:0]          count,
  input  logic [N_WB-1:0]         wb_valid,
  input  logic [N_WB*TAG_W-1:0]   wb_tag,
  input  logic [N_WB*32-1:0]      wb_data,
  input  logic [N_WB-1:0]         wb_taken,
  input  logic [N_WB*32-1:0]      wb_pc,
  input  logic                    rd1_valid,
  input  logic [TAG_W-1:0]        rd1_tag,
  output logic                    rd1_hit,
  output logic [31:0]             rd1_data,
  input  logic                    rd2_valid,
  input  logic [TAG_W-1:0]        rd2_tag,
  output logic                    rd2_hit,
  output logic [31:0]             rd2_data,
  output logic                    commit_valid,
  output logic [REG_W-1:0]        commit_dest,
  output logic [TAG_W-1:0]        commit_tag,
  output logic [31:0]             commit_data,
  output logic                    lsb_commit,
  output logic [TAG_W-1:0]        lsb_tag,
  output logic                    flush,
  output logic [31:0]             flush_pc
);
  localparam logic [2:0] T_REG = 3'd0, T_LOAD = 3'd1, T_STORE = 3'd2, T_PC = 3'd3, T_PCREG = 3'd4;

  logic [TAG_W-1:0] r_head, r_tail;
  logic [TAG_W:0]   r_count;
  logic [DEPTH-1:0] r_ready, r_sent, r_taken;
  logic [2:0]       r_type [DEPTH];
  logic [REG_W-1:0] r_dest [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [31:0]      r_pc   [DEPTH];

  logic             r_commit_valid, r_lsb_commit, r_flush;
  logic [REG_W-1:0] r_commit_dest;
  logic [TAG_W-1:0] r_commit_tag, r_lsb_tag;
  logic [31:0]      r_commit_data, r_flush_pc;

  logic             w_full, w_empty, w_alloc, w_commit, w_commit_wr, w_flush, w_lsb_issue;
  logic [2:0]       w_head_type;
  logic [TAG_W-1:0] w_wb_tag [N_WB];
  logic [1:0]       w_rd_valid, w_rd_hit;
  logic [TAG_W-1:0] w_rd_tag [2];
  logic [31:0]      w_rd_data [2];

  // Handshake: an allocation is taken on an rdy edge when alloc_valid && !full; write-backs are
  // unconditional strobes on rdy edges. Neither is applied on an edge that flushes.
  assign w_full      = (r_count == (TAG_W+1)'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_alloc     = alloc_valid && !w_full;
  assign w_head_type = r_type[r_head];
  assign w_commit    = !w_empty && r_ready[r_head];
  assign w_commit_wr = w_commit && (w_head_type == T_REG || w_head_type == T_LOAD ||
                                    w_head_type == T_PCREG);
  assign w_flush     = w_commit && (w_head_type == T_PC || w_head_type == T_PCREG) && r_taken[r_head];
  assign w_lsb_issue = !w_empty && (w_head_type == T_LOAD || w_head_type == T_STORE) && !r_sent[r_head];

  always_comb begin
    for (int i = 0; i < N_WB; i++) w_wb_tag[i] = wb_tag[i*TAG_W +: TAG_W];
  end

  assign w_rd_valid  = {rd2_valid, rd1_valid};
  assign w_rd_tag[0] = rd1_tag;
  assign w_rd_tag[1] = rd2_tag;

  // Stored ready entry beats any bypass; among channels the lowest index wins (assigned last).
  always_comb begin
    w_rd_hit  = '0;
    w_rd_data = '{default: '0};
    for (int p = 0; p < 2; p++) begin
`ifdef ROB_WB_BYPASS_EN
      for (int i = N_WB-1; i >= 0; i--) begin
        if (wb_valid[i] && w_wb_tag[i] == w_rd_tag[p]) begin
          w_rd_hit[p]  = 1'b1;
          w_rd_data[p] = wb_data[i*32 +: 32];
        end
      end
`endif
      if (r_ready[w_rd_tag[p]]) begin
        w_rd_hit[p]  = 1'b1;
        w_rd_data[p] = r_data[w_rd_tag[p]];
      end
      if (!w_rd_valid[p]) begin
        w_rd_hit[p]  = 1'b0;
        w_rd_data[p] = '0;
      end
    end
  end

  // Entry payload needs no reset: ready/sent/count decide what is live.
  always_ff @(posedge clk) begin
    if (rdy && !w_flush) begin
      if (w_alloc) begin
        r_type[r_tail] <= alloc_type;
        r_dest[r_tail] <= alloc_dest;
      end
      for (int i = 0; i < N_WB; i++) begin
        if (wb_valid[i]) begin
          r_data[w_wb_tag[i]]  <= wb_data[i*32 +: 32];
          r_pc[w_wb_tag[i]]    <= wb_pc[i*32 +: 32];
          r_taken[w_wb_tag[i]] <= wb_taken[i] &&
                                  (r_type[w_wb_tag[i]] == T_PC || r_type[w_wb_tag[i]] == T_PCREG);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_ready        <= '0;
      r_sent         <= '0;
      r_commit_valid <= 1'b0;
      r_commit_dest  <= '0;
      r_commit_tag   <= '0;
      r_commit_data  <= '0;
      r_lsb_commit   <= 1'b0;
      r_lsb_tag      <= '0;
      r_flush        <= 1'b0;
      r_flush_pc     <= '0;
    end else if (rdy) begin
      r_commit_valid <= 1'b0;
      r_lsb_commit   <= 1'b0;
      r_flush        <= 1'b0;
      if (w_commit_wr) begin
        r_commit_valid <= 1'b1;
        r_commit_dest  <= r_dest[r_head];
        r_commit_tag   <= r_head;
        r_commit_data  <= r_data[r_head];
      end
      if (w_flush) begin
        r_flush    <= 1'b1;
        r_flush_pc <= r_pc[r_head];
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_ready    <= '0;
        r_sent     <= '0;
      end else begin
        if (w_lsb_issue) begin
          r_lsb_commit     <= 1'b1;
          r_lsb_tag        <= r_head;
          r_sent[r_head]   <= 1'b1;
        end
        if (w_alloc) begin
          r_ready[r_tail] <= 1'b0;
          r_sent[r_tail]  <= 1'b0;
          r_tail          <= r_tail + TAG_W'(1);
        end
        for (int i = 0; i < N_WB; i++) begin
          if (wb_valid[i]) r_ready[w_wb_tag[i]] <= 1'b1;
        end
        if (w_commit) r_head <= r_head + TAG_W'(1);
        if (w_alloc && !w_commit)      r_count <= r_count + (TAG_W+1)'(1);
        else if (!w_alloc && w_commit) r_count <= r_count - (TAG_W+1)'(1);
      end
    end
  end

  assign alloc_tag    = r_tail;
  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = r_count;
  assign rd1_hit      = w_rd_hit[0];
  assign rd1_data     = w_rd_data[0];
  assign rd2_hit      = w_rd_hit[1];
  assign rd2_data     = w_rd_data[1];
  assign commit_valid = r_commit_valid;
  assign commit_dest  = r_commit_dest;
  assign commit_tag   = r_commit_tag;
  assign commit_data  = r_commit_data;
  assign lsb_commit   = r_lsb_commit;
  assign lsb_tag      = r_lsb_tag;
  assign flush        = r_flush;
  assign flush_pc     = r_flush_pc;
endmodule
